sram_preload_arbiter: RTL and testbench

Synthesizable preload sequencer and port arbiter for the 128-bit, 16-byte-lane system SRAM behind the AXI slave. After a start pulse it optionally wipes the array. It then packs a 32-bit instruction-image word stream and a 32-bit data-image word stream into 128-bit lines and writes them to their regions. Only then does it grant the SRAM port to the AXI slave datapath. This gives hardware-equivalent, cycle-accurate program loading for emulation and FPGA builds.

---
 rtl/sram_preload_pkg.sv | 23 ++
 rtl/sram_line_packer.sv | 46 ++++
 rtl/sram_preload_arbiter.sv | 158 +++++++++++++++
 tb/tb_sram_preload_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_preload_pkg.sv
// Shared line geometry, FSM state encoding and the word-to-byte-lane helper
// for the SRAM preload arbiter.
package sram_preload_pkg;

  localparam int LANES          = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_W         = 128;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WIPE      = 3'd1;
  localparam state_t ST_LOAD_INST = 3'd2;
  localparam state_t ST_LOAD_DATA = 3'd3;
  localparam state_t ST_WRITE     = 3'd4;
  localparam state_t ST_DONE      = 3'd5;

  // The most significant byte of a word lands in the lowest lane of its slot.
  function automatic logic [31:0] word_to_lanes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sram_line_packer.sv
// Collects four accepted 32-bit words into one 128-bit line; k counts the
// words already placed and full_o flags the accept that completes the line.
module sram_line_packer
  import sram_preload_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic              accept_i,
  input  logic [31:0]       word_i,
  output logic [LINE_W-1:0] line_o,
  output logic              full_o
);

  localparam int K_W = $clog2(WORDS_PER_LINE);

  logic [K_W-1:0]    k_q, k_d;
  logic [LINE_W-1:0] line_q, line_d;

  // Place the accepted word into slot k and advance k, wrapping after the last slot.
  always_comb begin
    k_d    = k_q;
    line_d = line_q;
    if (accept_i) begin
      k_d                = k_q + K_W'(1);
      line_d[32*k_q +: 32] = word_to_lanes(word_i);
    end else begin
      k_d    = k_q;
      line_d = line_q;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      k_q    <= '0;
      line_q <= '0;
    end else begin
      k_q    <= k_d;
      line_q <= line_d;
    end
  end

  assign line_o = line_q;
  assign full_o = accept_i && (k_q == K_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/sram_preload_arbiter.sv
// Preload sequencer and SRAM port arbiter: optional wipe, instruction and data
// image load, then hand the port to the AXI slave. Wipe phase is built only
// when SRAM_PRELOAD_WIPE_EN is defined.
module sram_preload_arbiter
  import sram_preload_pkg::*;
#(
  parameter int ADDR_W     = 19,
  parameter int WIPE_LINES = 32768,
  parameter int IMG_LINES  = 16384,
  parameter int INST_BASE  = 0,
  parameter int DATA_BASE  = 16384
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start_i,
  input  logic              src_valid_i,
  output logic              src_ready_o,
  input  logic [31:0]       src_data_i,
  input  logic              slv_req_i,
  input  logic              slv_we_i,
  input  logic [ADDR_W-1:0] slv_addr_i,
  input  logic [LINE_W-1:0] slv_wdata_i,
  input  logic [LANES-1:0]  slv_be_i,
  output logic              slv_gnt_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  output logic [LANES-1:0]  mem_be_o,
  output logic              busy_o,
  output logic              done_o
);

  // One extra bit so the counter can represent a full image without wrapping.
  localparam int CNT_W = ADDR_W + 1;

  state_t            state_q, state_d;
  logic              ret_data_q, ret_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept_s, line_full_s;
  logic [LINE_W-1:0] line_s;
  logic [ADDR_W-1:0] base_s;

  assign src_ready_o = (state_q == ST_LOAD_INST) || (state_q == ST_LOAD_DATA);
  assign accept_s    = src_valid_i && src_ready_o;
  assign slv_gnt_o   = (state_q == ST_DONE);
  assign done_o      = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign base_s      = ret_data_q ? ADDR_W'(DATA_BASE) : ADDR_W'(INST_BASE);

  sram_line_packer u_packer (
    .clk      (clk),
    .rst_b    (rst_b),
    .accept_i (accept_s),
    .word_i   (src_data_i),
    .line_o   (line_s),
    .full_o   (line_full_s)
  );

  // Sequencer next-state; WRITE returns to the image phase recorded in ret_data.
  always_comb begin
    state_d    = state_q;
    ret_data_d = ret_data_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          cnt_d      = '0;
          ret_data_d = 1'b0;
`ifdef SRAM_PRELOAD_WIPE_EN
          state_d    = ST_WIPE;
`else
          state_d    = ST_LOAD_INST;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_WIPE: begin
        if (cnt_q == CNT_W'(WIPE_LINES - 1)) begin
          cnt_d   = '0;
          state_d = ST_LOAD_INST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOAD_INST, ST_LOAD_DATA: begin
        if (line_full_s) begin
          ret_data_d = (state_q == ST_LOAD_DATA);
          state_d    = ST_WRITE;
        end else begin
          state_d = state_q;
        end
      end
      ST_WRITE: begin
        if (cnt_q == CNT_W'(IMG_LINES - 1)) begin
          cnt_d   = '0;
          state_d = ret_data_q ? ST_DONE : ST_LOAD_DATA;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ret_data_q ? ST_LOAD_DATA : ST_LOAD_INST;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ST_IDLE;
      ret_data_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ret_data_q <= ret_data_d;
      cnt_q      <= cnt_d;
    end
  end

  // SRAM port mux: loader writes while loading, slave passes straight through in DONE.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    case (state_q)
      ST_WIPE: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = cnt_q[ADDR_W-1:0];
        mem_be_o   = {LANES{1'b1}};
      end
      ST_WRITE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = base_s + cnt_q[ADDR_W-1:0];
        mem_wdata_o = line_s;
        mem_be_o    = {LANES{1'b1}};
      end
      ST_DONE: begin
        mem_req_o   = slv_req_i;
        mem_we_o    = slv_we_i;
        mem_addr_o  = slv_addr_i;
        mem_wdata_o = slv_wdata_i;
        mem_be_o    = slv_be_i;
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_preload_arbiter.sv
// Self-checking bench for sram_preload_arbiter with a small SRAM geometry;
// expected SRAM contents are derived from the image word lists and lane rules.
`timescale 1ns/1ps
module tb_sram_preload_arbiter;

  localparam int AW = 6;
  localparam int WL = 8;
  localparam int IL = 4;
  localparam int IB = 2;
  localparam int DB = 62;
  localparam int NL = 1 << AW;
  localparam int NW = 4 * IL;
`ifdef SRAM_PRELOAD_WIPE_EN
  localparam int WEFF = WL;
`else
  localparam int WEFF = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          start = 1'b0;
  logic          src_valid = 1'b0;
  logic [31:0]   src_data = 32'h0;
  logic          slv_req = 1'b0;
  logic          slv_we = 1'b0;
  logic [AW-1:0] slv_addr = '0;
  logic [127:0]  slv_wdata = '0;
  logic [15:0]   slv_be = 16'h0;
  logic          src_ready, slv_gnt, mem_req, mem_we, busy, done;
  logic [AW-1:0] mem_addr;
  logic [127:0]  mem_wdata;
  logic [15:0]   mem_be;

  int tests = 0;
  int fails = 0;

  logic [127:0] sram       [NL];
  logic [127:0] preset_val [NL];
  logic [127:0] exp_mem    [NL];
  logic [31:0]  words      [2*NW];
  logic [15:0]  be_inst;
  bit           preset_go = 1'b0;

  always #5 clk = ~clk;

  sram_preload_arbiter #(
    .ADDR_W(AW), .WIPE_LINES(WL), .IMG_LINES(IL), .INST_BASE(IB), .DATA_BASE(DB)
  ) dut (
    .clk(clk), .rst_b(rst_b), .start_i(start),
    .src_valid_i(src_valid), .src_ready_o(src_ready), .src_data_i(src_data),
    .slv_req_i(slv_req), .slv_we_i(slv_we), .slv_addr_i(slv_addr),
    .slv_wdata_i(slv_wdata), .slv_be_i(slv_be), .slv_gnt_o(slv_gnt),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .busy_o(busy), .done_o(done)
  );

  // Byte-enabled SRAM array behind the port, with a bench-driven bulk preset.
  always @(posedge clk) begin
    logic [127:0] tmp;
    if (preset_go) begin
      for (int l = 0; l < NL; l++) sram[l] <= preset_val[l];
    end else if (mem_req && mem_we) begin
      tmp = sram[mem_addr];
      for (int n = 0; n < 16; n++) if (mem_be[n]) tmp[8*n +: 8] = mem_wdata[8*n +: 8];
      sram[mem_addr] <= tmp;
    end
  end

  // Line built from four words: lane 4k+j holds byte (3-j) of word k.
  function automatic logic [127:0] ref_line(input int first);
    logic [127:0] l;
    logic [31:0]  w;
    for (int n = 0; n < 16; n++) begin
      w = words[first + n / 4];
      l[8*n +: 8] = w[8*(3 - (n % 4)) +: 8];
    end
    return l;
  endfunction

  task automatic gen_and_preset(input bit fixed_first);
    for (int l = 0; l < NL; l++) begin
      preset_val[l] = {$urandom, $urandom, $urandom, 24'h0, 8'(l + 1)};
      exp_mem[l]    = preset_val[l];
    end
    for (int i = 0; i < 2*NW; i++) words[i] = $urandom;
    if (fixed_first) begin
      words[0] = 32'h11223344;
      words[1] = 32'h0;
      words[2] = 32'h0;
      words[3] = 32'h0;
    end
    for (int l = 0; l < WEFF; l++) exp_mem[l] = '0;
    for (int l = 0; l < IL; l++) begin
      exp_mem[(IB + l) % NL] = ref_line(4*l);
      exp_mem[(DB + l) % NL] = ref_line(NW + 4*l);
    end
    @(negedge clk); preset_go = 1'b1;
    @(negedge clk); preset_go = 1'b0;
  endtask

  // Supplies image words with the chosen valid pattern until done, timeout, or abort.
  task automatic feed(input int pat, input int abort_at, output int cycles,
                      output bit got_done, output int acc);
    bit tog = 1'b0;
    bit v;
    int idx = 0;
    cycles = 0;
    got_done = 1'b0;
    while (cycles < 1000) begin
      @(negedge clk);
      start = 1'b0;
      if (abort_at >= 0 && idx == abort_at) begin
        rst_b = 1'b0;
        break;
      end
      cycles++;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL busy_during_load cycle %0d: got %b want 1", cycles, busy);
      end
      if (mem_req && mem_we) begin
        tests++;
        if (src_ready !== 1'b0) begin
          fails++;
          $display("FAIL ready_in_write cycle %0d: got %b want 0", cycles, src_ready);
        end
        if (mem_addr == AW'(IB)) be_inst = mem_be;
      end
      case (pat)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (idx >= 2*NW) v = 1'b0;
      src_valid = v;
      src_data  = v ? words[idx] : $urandom;
      if (v && src_ready) idx++;
    end
    src_valid = 1'b0;
    acc = idx;
  endtask

  task automatic check_mem(input string tag);
    for (int l = 0; l < NL; l++) begin
      tests++;
      if (sram[l] !== exp_mem[l]) begin
        fails++;
        $display("FAIL %s line %0d: got %h want %h", tag, l, sram[l], exp_mem[l]);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    tests++;
    if ({src_ready, slv_gnt, mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, done} !== '0) begin
      fails++;
      $display("FAIL %s: got rdy=%b gnt=%b req=%b we=%b addr=%h wd=%h be=%h busy=%b done=%b want all 0",
               tag, src_ready, slv_gnt, mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy, done);
    end
  endtask

  task automatic run_load(input int pat, input bit fixed_first, input bit check_time, input string tag);
    int cyc, acc;
    bit gd;
    gen_and_preset(fixed_first);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    feed(pat, -1, cyc, gd, acc);
    tests++;
    if (!gd) begin fails++; $display("FAIL %s_timeout: done=%b after %0d cycles want 1", tag, done, cyc); end
    tests++;
    if (acc != 2*NW) begin fails++; $display("FAIL %s_words: got %0d accepted want %0d", tag, acc, 2*NW); end
    if (check_time) begin
      tests++;
      if (cyc != WEFF + 10*IL + 1)
        begin fails++; $display("FAIL %s_latency: got %0d want %0d", tag, cyc, WEFF + 10*IL + 1); end
    end
    tests++;
    if ({busy, done, slv_gnt, src_ready} !== 4'b0110)
      begin fails++; $display("FAIL %s_final: busy/done/gnt/rdy got %b want 0110", tag, {busy, done, slv_gnt, src_ready}); end
    check_mem(tag);
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_values");
    rst_b = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_wipe_and_first_line();
    be_inst = 16'h0;
    run_load(0, 1'b1, 1'b1, "full_rate");
    tests++;
    if (sram[IB][31:0] !== 32'h44332211)
      begin fails++; $display("FAIL first_line_lanes: got %h want 44332211", sram[IB][31:0]); end
    tests++;
    if (be_inst !== 16'hFFFF) begin fails++; $display("FAIL first_line_be: got %h want ffff", be_inst); end
    tests++;
    if (sram[WL] !== preset_val[WL])
      begin fails++; $display("FAIL wipe_boundary_untouched: got %h want %h", sram[WL], preset_val[WL]); end
`ifdef SRAM_PRELOAD_WIPE_EN
    tests++;
    if (sram[WL-1] !== 128'h0) begin fails++; $display("FAIL wipe_last_line: got %h want 0", sram[WL-1]); end
`endif
  endtask

  task automatic test_passthrough();
    logic [127:0] wd;
    wd = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    slv_req = 1'b1; slv_we = 1'b1; slv_addr = AW'(5); slv_wdata = wd; slv_be = 16'h000F;
    #1;
    tests++;
    if ({slv_gnt, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 1'b1, 1'b1, AW'(5), 16'h000F, wd})
      begin fails++; $display("FAIL slave_passthrough: got gnt=%b req=%b we=%b addr=%0d be=%h wd=%h want 1 1 1 5 000f %h",
                              slv_gnt, mem_req, mem_we, mem_addr, mem_be, mem_wdata, wd); end
    exp_mem[5][31:0] = wd[31:0];
    @(negedge clk);
    slv_req = 1'b0; slv_we = 1'b0; slv_be = 16'h0;
    tests++;
    if (sram[5] !== exp_mem[5]) begin fails++; $display("FAIL slave_write_be: got %h want %h", sram[5], exp_mem[5]); end
  endtask

  task automatic test_reload();
    int cyc, acc;
    bit gd;
    gen_and_preset(1'b0);
    @(negedge clk);
    start = 1'b1; slv_req = 1'b1; slv_we = 1'b0; slv_addr = AW'(9);
    slv_wdata = {4{32'hA5A5_0001}}; slv_be = 16'hFFFF;
    #1;
    tests++;
    if ({slv_gnt, mem_req, mem_addr} !== {1'b1, 1'b1, AW'(9)})
      begin fails++; $display("FAIL reload_start_cycle: got gnt=%b req=%b addr=%0d want 1 1 9", slv_gnt, mem_req, mem_addr); end
    @(negedge clk);
    start = 1'b0;
    #1;
    tests++;
    if ({slv_gnt, busy, done, mem_req, mem_we, mem_addr, mem_wdata} !==
        {1'b0, 1'b1, 1'b0, (WEFF > 0), (WEFF > 0), AW'(0), 128'h0})
      begin fails++; $display("FAIL reload_gnt_drop: got gnt=%b busy=%b done=%b req=%b we=%b addr=%0d wd=%h want 0 1 0 %b %b 0 0",
                              slv_gnt, busy, done, mem_req, mem_we, mem_addr, mem_wdata, WEFF > 0, WEFF > 0); end
    slv_req = 1'b0; slv_be = 16'h0; slv_wdata = '0;
    feed(0, -1, cyc, gd, acc);
    tests++;
    if (!gd || acc != 2*NW)
      begin fails++; $display("FAIL reload_complete: got done=%b words=%0d want 1 %0d", gd, acc, 2*NW); end
    check_mem("reload");
  endtask

  task automatic test_reset_mid();
    int cyc, acc;
    bit gd;
    gen_and_preset(1'b0);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    feed(2, NW + 4 + 2, cyc, gd, acc);
    #1;
    tests++;
    if (acc != NW + 6) begin fails++; $display("FAIL midreset_reach: got %0d words want %0d", acc, NW + 6); end
    check_idle_outputs("midreset_outputs");
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    run_load(2, 1'b0, 1'b0, "restart");
  endtask

  initial begin
    test_reset();
    test_wipe_and_first_line();
    test_passthrough();
    run_load(1, 1'b0, 1'b0, "toggle_valid");
    test_reload();
    run_load(2, 1'b0, 1'b0, "random_valid");
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
